hilo_divider: RTL and testbench
===============================

Name: hilo_divider

Overview:
- Multi-cycle radix-2 restoring divider that produces the 64-bit {hi, lo} value written into the register file's HI/LO pair for MIPS DIV/DIVU.
- Executes in EX. Its result travels down the pipeline to writeback, which drives the hilo write with flagW[2] set.
- The pipeline stalls on `busy`. The block accepts one operation at a time.

Parameters:
WIDTH, 32, operand width; the result is 2*WIDTH bits.

Ports:
clk  in  1  clock; all state updates on posedge.
resetn  in  1  synchronous active-low reset.
start  in  1  request a divide; sampled only in IDLE.
signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start.
annul  in  1  flush (exception or branch squash); abort the current operation.
a  in  WIDTH  dividend; sampled with start.
b  in  WIDTH  divisor; sampled with start.
busy  out  1  high while an operation is in flight (BUSY or DONE state).
result_valid  out  1  one-cycle pulse when `result` is final.
result  out  2*WIDTH  {remainder (hi), quotient (lo)}; holds its value until the next accepted start.
div_zero  out  1  set with result_valid when b == 0; holds its value with `result`.

Behaviour:
- Reset (resetn == 0 at a posedge):
  - state goes to IDLE.
  - busy = 0, result_valid = 0, result = 0, div_zero = 0, iteration counter = 0.
  - Reset wins over every other input, including mid-operation.
- States:
  - IDLE → BUSY on start & !annul & (b != 0).
    - Latch |a| and |b| (two's-complement absolute value only when signed_div = 1).
    - Latch the quotient sign (a[W-1] ^ b[W-1]) and the remainder sign (a[W-1]), both gated by signed_div.
    - Clear the partial remainder and the counter.
  - IDLE → DONE on start & !annul & (b == 0).
    - result = {a, all-ones}; div_zero = 1.
  - BUSY: one quotient bit per cycle, MSB first.
    - Shift {rem, dvd} left by 1.
    - If rem >= |b|: rem -= |b| and set the quotient bit.
    - Counter increments each cycle. After the WIDTH-th iteration (counter == WIDTH-1) → DONE.
  - DONE: apply sign correction and register `result`.
    - Quotient is negated when the quotient sign is set.
    - Remainder is negated when the remainder sign is set.
    - result_valid = 1 for this single cycle. Next state is IDLE.
- Latency: start sampled at edge T → result_valid high in the cycle after edge T+WIDTH+1, i.e. 33 cycles for WIDTH = 32. The divide-by-zero path takes 1 cycle.
- busy is high in BUSY and DONE and low in IDLE.
- Arithmetic: the internal partial remainder is WIDTH+1 bits to avoid compare overflow.
  - Signed 0x8000_0000 / -1: quotient 0x8000_0000, remainder 0 (wrap, no trap).
- Simultaneous events:
  - start while busy: ignored. The in-flight operation is unaffected.
  - annul in BUSY or DONE: → IDLE at the next edge. No result_valid; result and div_zero keep their previous values.
  - annul & start in IDLE: annul wins, and the start is dropped.
  - annul in the DONE cycle suppresses that cycle's result_valid and result update.
- The result register is written only in DONE or on the divide-by-zero transition.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, on an accepted start with b != 0 and |a| < |b| (unsigned compare of the absolute values), go directly to DONE.
  - DONE produces quotient 0 and remainder a (the original signed dividend), so result_valid arrives 1 cycle after start.
  - When a == 0, the same path applies.
- Undefined: every non-zero-divisor operation takes the full WIDTH+1 cycles.
- Divide-by-zero handling is identical in both builds.

Test Plan:
- DIVU a=7, b=2, start 1 cycle → busy high next cycle; result_valid at cycle 33; result = {32'h1, 32'h3}; div_zero = 0.
- DIV a=-7 (0xFFFF_FFF9), b=2 → result = {32'hFFFF_FFFF, 32'hFFFF_FFFD} (rem -1, quot -3) at cycle 33.
- DIV a=0x8000_0000, b=0xFFFF_FFFF → result = {32'h0, 32'h8000_0000}, no X, valid at cycle 33.
- DIVU a=5, b=0 → result_valid 1 cycle later; result = {32'h5, 32'hFFFF_FFFF}; div_zero = 1; busy low afterwards.
- Abort paths:
  - DIVU 100/7, annul asserted at cycle 10 → IDLE next edge; no result_valid; result still holds the prior value.
  - New start 100/7 → {32'h2, 32'hE} after 33 cycles.
  - Repeat with resetn low at cycle 10 → all outputs 0 next edge.
- start re-pulsed with a=1, b=1 during BUSY of 9/3 → ignored; result = {0, 3}.
- With DIV_EARLY_OUT_EN, DIVU 3/10 → {32'h3, 32'h0} in 1 cycle.

Source files
------------

// File: rtl/hilo_divider.sv
// -----------------------------------------------------------------------------
// hilo_divider
//
// Multi-cycle radix-2 restoring divider producing the 64-bit {hi, lo} value
// for MIPS DIV / DIVU: hi = remainder, lo = quotient. One operation at a time.
// The pipeline stalls while busy is high.
//
// Optional build macro: DIV_EARLY_OUT_EN
//   defined   : when |a| < |b| (including a == 0), the divide skips the
//               iteration loop and finishes with quotient 0 and remainder a.
//   undefined : every non-zero-divisor operation takes the full loop.
//
// Ports:
//   clk          in   clock, all state updates on posedge
//   resetn       in   synchronous active-low reset
//   start        in   divide request, sampled only in IDLE
//   signed_div   in   1 = DIV (signed), 0 = DIVU; sampled with start
//   annul        in   flush; aborts the operation in flight
//   a, b         in   dividend / divisor, sampled with start
//   busy         out  operation in flight (BUSY or DONE)
//   result_valid out  one-cycle pulse when result is final
//   result       out  {remainder, quotient}; held until the next result
//   div_zero     out  divisor was zero; held alongside result
//   dbg_state    out  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: a request is accepted on a clock edge where start is high,
// annul is low and the block is in IDLE (busy low). start while busy is
// ignored. Completion is signalled by result_valid, high for exactly one
// cycle, with result and div_zero valid from that cycle onward. There is no
// back-pressure on the result side.
// -----------------------------------------------------------------------------
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 result_valid,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_zero,
    output logic [1:0]           dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0]       dvd_q, dvd_d;       // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]       dvs_q, dvs_d;       // |divisor|
    logic                   qneg_q, qneg_d;
    logic                   rneg_q, rneg_d;
    logic                   zdiv_q, zdiv_d;
    logic [2*WIDTH-1:0]     result_q, result_d;
    logic                   div_zero_q, div_zero_d;
    logic                   valid_q, valid_d;

    logic [WIDTH-1:0]       abs_a, abs_b;
    logic [WIDTH:0]         shift_rem;
    logic                   rem_ge;
    logic [WIDTH-1:0]       rem_sub;
    logic [WIDTH-1:0]       quot_fix, rem_fix;

    // Absolute values are taken only for signed divides; 0x8000_0000 maps to
    // itself, which is the correct unsigned magnitude.
    assign abs_a = (signed_div && a[WIDTH-1]) ? -a : a;
    assign abs_b = (signed_div && b[WIDTH-1]) ? -b : b;

    // The shifted remainder is one bit wider than the divisor so the compare
    // cannot overflow. When it is >= divisor the true difference fits in
    // WIDTH bits, so a WIDTH-bit subtraction is exact.
    assign shift_rem = {rem_q, dvd_q[WIDTH-1]};
    assign rem_ge    = (shift_rem >= {1'b0, dvs_q});
    assign rem_sub   = shift_rem[WIDTH-1:0] - dvs_q;

    assign quot_fix = qneg_q ? -dvd_q : dvd_q;
    assign rem_fix  = rneg_q ? -rem_q : rem_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        zdiv_d     = zdiv_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        valid_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    cnt_d  = '0;
                    qneg_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg_d = signed_div & a[WIDTH-1];
                    if (b == '0) begin
                        // Divide by zero: DONE emits {a, all-ones} unchanged.
                        state_d = DONE;
                        zdiv_d  = 1'b1;
                        rem_d   = a;
                        dvd_d   = '1;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                    end else begin
                        zdiv_d = 1'b0;
                        dvs_d  = abs_b;
`ifdef DIV_EARLY_OUT_EN
                        if (abs_a < abs_b) begin
                            // Quotient 0; the remainder sign fix restores a.
                            state_d = DONE;
                            rem_d   = abs_a;
                            dvd_d   = '0;
                        end else begin
                            state_d = BUSY;
                            rem_d   = '0;
                            dvd_d   = abs_a;
                        end
`else
                        state_d = BUSY;
                        rem_d   = '0;
                        dvd_d   = abs_a;
`endif
                    end
                end
            end

            BUSY: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_ge ? rem_sub : shift_rem[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], rem_ge};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                if (!annul) begin
                    result_d   = {rem_fix, quot_fix};
                    div_zero_d = zdiv_q;
                    valid_d    = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            zdiv_q     <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            zdiv_q     <= zdiv_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
            valid_q    <= valid_d;
        end
    end

    assign busy         = (state_q == BUSY) || (state_q == DONE);
    assign result_valid = valid_q;
    assign result       = result_q;
    assign div_zero     = div_zero_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_hilo_divider.sv
// -----------------------------------------------------------------------------
// tb_hilo_divider
//
// Directed test of hilo_divider (WIDTH = 32) with hand-computed expected
// results. Expected results are queued in exp_q and consumed when
// result_valid is observed. Early-out latency expectations follow
// DIV_EARLY_OUT_EN.
// -----------------------------------------------------------------------------
module tb_hilo_divider;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic              start;
    logic              signed_div;
    logic              annul;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic              busy;
    logic              result_valid;
    logic [2*W-1:0]    result;
    logic              div_zero;
    logic [1:0]        dbg_state;

    hilo_divider #(.WIDTH(W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .signed_div   (signed_div),
        .annul        (annul),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .div_zero     (div_zero),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    logic [2*W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (result_valid === 1'b1) valid_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Returns #1 after the edge that samples start (edge T).
    task automatic start_op(input logic sd, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start      = 1'b1;
        signed_div = sd;
        a          = av;
        b          = bv;
        @(posedge clk);
        #1;
        start      = 1'b0;
    endtask

    // Waits for result_valid, counting edges from the current point.
    task automatic wait_result(input string tag, input logic [2*W-1:0] exp_res,
                               input logic exp_dz, input int exp_lat);
        int n;
        logic seen;
        logic [2*W-1:0] e;
        n    = 0;
        seen = 1'b0;
        exp_q.push_back(exp_res);
        check({tag, ".busy_start"}, 64'(busy), 64'd1);
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (result_valid === 1'b1) begin
                seen = 1'b1;
                n    = i;
            end
        end
        e = exp_q.pop_front();
        check({tag, ".latency"}, 64'(n), 64'(exp_lat));
        check({tag, ".result"}, result, e);
        check({tag, ".div_zero"}, 64'(div_zero), 64'(exp_dz));
        check({tag, ".busy_end"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, 64'(result_valid), 64'd0);
        check({tag, ".hold"}, result, e);
    endtask

    // ---------------- stimulus ----------------
    int vc;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        annul      = 1'b0;
        a          = '0;
        b          = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy",   64'(busy), 64'd0);
        check("rst.valid",  64'(result_valid), 64'd0);
        check("rst.result", result, 64'd0);
        check("rst.dz",     64'(div_zero), 64'd0);
        check("rst.state",  64'(dbg_state), 64'd0);
        resetn = 1'b1;

        // Basic unsigned and signed divides
        start_op(1'b0, 32'd7, 32'd2);
        wait_result("divu_7_2", {32'h1, 32'h3}, 1'b0, 33);

        start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_m7_2", {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 33);

        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_min_m1", {32'h0, 32'h8000_0000}, 1'b0, 33);

        start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_result("div_7_m2", {32'h1, 32'hFFFF_FFFD}, 1'b0, 33);

        start_op(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD);
        wait_result("div_m8_m3", {32'hFFFF_FFFE, 32'h2}, 1'b0, 33);

        // Divide by zero
        start_op(1'b0, 32'd5, 32'd0);
        wait_result("divu_5_0", {32'h5, 32'hFFFF_FFFF}, 1'b1, 1);

        // Annul in BUSY: no result, previous result and div_zero held
        start_op(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        vc = valid_cnt;
        check("annul_busy.state", 64'(dbg_state), 64'd0);
        check("annul_busy.busy",  64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("annul_busy.no_valid", 64'(valid_cnt - vc), 64'd0);
        check("annul_busy.result",   result, {32'h5, 32'hFFFF_FFFF});
        check("annul_busy.dz",       64'(div_zero), 64'd1);

        start_op(1'b0, 32'd100, 32'd7);
        wait_result("divu_100_7", {32'h2, 32'hE}, 1'b0, 33);

        // Annul during the DONE cycle
        start_op(1'b0, 32'd50, 32'd3);
        repeat (32) @(posedge clk);
        #1;
        check("annul_done.in_done", 64'(dbg_state), 64'd2);
        vc = valid_cnt;
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        check("annul_done.state", 64'(dbg_state), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("annul_done.no_valid", 64'(valid_cnt - vc), 64'd0);
        check("annul_done.result",   result, {32'h2, 32'hE});

        // annul and start together in IDLE: start dropped
        @(negedge clk);
        start = 1'b1;
        annul = 1'b1;
        a     = 32'd9;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        check("annul_start.busy",  64'(busy), 64'd0);
        check("annul_start.state", 64'(dbg_state), 64'd0);

        // Reset mid-operation
        start_op(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("rst_mid.busy",   64'(busy), 64'd0);
        check("rst_mid.valid",  64'(result_valid), 64'd0);
        check("rst_mid.result", result, 64'd0);
        check("rst_mid.dz",     64'(div_zero), 64'd0);
        check("rst_mid.state",  64'(dbg_state), 64'd0);

        // start re-pulsed during BUSY is ignored (6 edges already elapsed)
        start_op(1'b0, 32'd9, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 32'd1;
        b     = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_result("divu_9_3_repulse", {32'h0, 32'h3}, 1'b0, 27);

        // Dividend smaller than divisor (early-out path when enabled)
        start_op(1'b0, 32'd3, 32'd10);
        wait_result("divu_3_10", {32'h3, 32'h0}, 1'b0, EARLY_LAT);

        start_op(1'b1, 32'hFFFF_FFFD, 32'd10);
        wait_result("div_m3_10", {32'hFFFF_FFFD, 32'h0}, 1'b0, EARLY_LAT);

        start_op(1'b0, 32'd0, 32'd5);
        wait_result("divu_0_5", {32'h0, 32'h0}, 1'b0, EARLY_LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
